// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, FSM states and default idle byte for the SPI send/receive pair.
package spi_pkg;
    localparam int SPI_BYTE_W = 8;
    localparam logic [SPI_BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'hFF;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;
endpackage

// File: rtl/spi_send_fifo.sv
// spi_send_fifo: synchronous FIFO with full/empty flags and occupancy count.
module spi_send_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;

    // Extra pointer bit tells a full FIFO apart from an empty one.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = wr_ptr_q == rd_ptr_q;
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk)
        if (wr_en && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
endmodule

// File: rtl/spi_send.sv
// spi_send: slave-side SPI mode-0 transmitter fed by an AXI-Stream byte FIFO.
module spi_send
    import spi_pkg::*;
#(
    parameter int                    FIFO_DEPTH = 16,
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE  = IDLE_BYTE_DEFAULT
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [SPI_BYTE_W-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  spi_clk,
    input  logic                  spi_cs,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic                  tx_underrun,
    output logic                  tx_abort,
    output logic                  tx_frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [2:0]            cs_sync_q, clk_sync_q;
    logic                  cs_rise, cs_fall, sclk_rise, sclk_fall;
    state_e                state_q;
    logic [2:0]            bit_cnt_q;
    logic [SPI_BYTE_W-1:0] shift_q;
    logic                  last_q;
    logic                  wr, rd, full, empty;
    logic [SPI_BYTE_W:0]   rd_data;
    logic [AW:0]           count, count_d;

    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign sclk_rise = clk_sync_q[1] & ~clk_sync_q[2];
    assign sclk_fall = ~clk_sync_q[1] & clk_sync_q[2];

    assign wr      = s_axis_tvalid & s_axis_tready & ~full;
    assign rd      = (state_q == LOAD) & ~empty;
    assign count_d = count + (AW+1)'(wr) - (AW+1)'(rd);

    spi_send_fifo #(.W(SPI_BYTE_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .wr_en   (wr),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (rd),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn)
        if (!axi_aresetn) begin
            cs_sync_q     <= '0;
            clk_sync_q    <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            cs_sync_q     <= {cs_sync_q[1:0], spi_cs};
            clk_sync_q    <= {clk_sync_q[1:0], spi_clk};
            s_axis_tready <= count_d != (AW+1)'(FIFO_DEPTH);
        end

    always_ff @(posedge axi_aclk or negedge axi_aresetn)
        if (!axi_aresetn) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            last_q        <= 1'b0;
            spi_miso      <= 1'b1;
            spi_miso_oe   <= 1'b0;
            tx_underrun   <= 1'b0;
            tx_abort      <= 1'b0;
            tx_frame_done <= 1'b0;
        end else begin
            tx_underrun   <= 1'b0;
            tx_abort      <= 1'b0;
            tx_frame_done <= 1'b0;
            if (cs_fall) begin
                state_q     <= IDLE;
                bit_cnt_q   <= '0;
                spi_miso    <= 1'b1;
                spi_miso_oe <= 1'b0;
                tx_abort    <= (state_q == SHIFT) && (bit_cnt_q != 3'd0);
            end else begin
                case (state_q)
                    IDLE: if (cs_rise) state_q <= LOAD;
                    LOAD: begin
                        shift_q     <= empty ? IDLE_BYTE : rd_data[SPI_BYTE_W-1:0];
                        spi_miso    <= empty ? IDLE_BYTE[SPI_BYTE_W-1] : rd_data[SPI_BYTE_W-1];
                        last_q      <= ~empty & rd_data[SPI_BYTE_W];
                        tx_underrun <= empty;
                        spi_miso_oe <= 1'b1;
                        bit_cnt_q   <= '0;
                        state_q     <= SHIFT;
                    end
                    SHIFT:
                        if (sclk_rise) begin
                            bit_cnt_q     <= bit_cnt_q + 3'd1;
                            tx_frame_done <= (bit_cnt_q == 3'd7) && last_q;
                        end else if (sclk_fall) begin
                            // bit_cnt back at 0 means all 8 bits were sampled: fetch the next byte.
                            if (bit_cnt_q == 3'd0) state_q <= LOAD;
                            else begin
                                shift_q  <= shift_q << 1;
                                spi_miso <= shift_q[SPI_BYTE_W-2];
                            end
                        end
                    default: state_q <= IDLE;
                endcase
            end
        end
endmodule

// File: tb/tb_spi_send.sv
// tb_spi_send: directed and randomized SPI master exercises against a byte-queue reference model.
module tb_spi_send;
    logic       axi_aclk = 1'b0;
    logic       axi_aresetn = 1'b0;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_cs = 1'b0;
    logic       spi_miso, spi_miso_oe, tx_underrun, tx_abort, tx_frame_done;

    int vecs = 0, errs = 0;
    int und_seen = 0, abort_seen = 0, fd_seen = 0;
    int und_exp = 0, abort_exp = 0, fd_exp = 0;
    logic [8:0] model[$];

    spi_send dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .spi_clk       (spi_clk),
        .spi_cs        (spi_cs),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .tx_underrun   (tx_underrun),
        .tx_abort      (tx_abort),
        .tx_frame_done (tx_frame_done)
    );

    always #5 axi_aclk = ~axi_aclk;

    always @(negedge axi_aclk) begin
        if (tx_underrun) und_seen++;
        if (tx_abort) abort_seen++;
        if (tx_frame_done) fd_seen++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_axis_tdata = d;
        s_axis_tlast = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 50) begin
            @(negedge axi_aclk);
            n++;
        end
        if (n >= 50) chk("push_timeout", 32'(n), 32'd0);
        @(posedge axi_aclk);
        #1;
        s_axis_tvalid = 1'b0;
        model.push_back({l, d});
        @(negedge axi_aclk);
    endtask

    task automatic cs_on();
        @(negedge axi_aclk);
        spi_cs = 1'b1;
        repeat (8) @(negedge axi_aclk);
    endtask

    task automatic cs_off();
        spi_clk = 1'b0;
        spi_cs = 1'b0;
        repeat (8) @(negedge axi_aclk);
    endtask

    // Master samples MISO just before each rising edge; on the final bit of a window clk stays high until cs drops.
    task automatic xfer(input int nbits, input bit fin, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < nbits; i++) begin
            b = {b[6:0], spi_miso};
            spi_clk = 1'b1;
            repeat (4) @(negedge axi_aclk);
            if (!(fin && i == nbits - 1)) begin
                spi_clk = 1'b0;
                repeat (4) @(negedge axi_aclk);
            end
        end
    endtask

    task automatic window(input int nbytes, input int pbits, input bit pre_on);
        logic [7:0] got;
        logic [8:0] e;
        int total, nb;
        total = nbytes + ((pbits > 0) ? 1 : 0);
        if (!pre_on) cs_on();
        for (int k = 0; k < total; k++) begin
            nb = (k < nbytes) ? 8 : pbits;
            if (model.size() > 0) e = model.pop_front();
            else begin
                e = 9'h0FF;
                und_exp++;
            end
            xfer(nb, k == total - 1, got);
            if (nb == 8) begin
                chk("miso_byte", 32'(got), 32'(e[7:0]));
                if (e[8]) fd_exp++;
            end else abort_exp++;
        end
        cs_off();
        chk("underrun_cnt", 32'(und_seen), 32'(und_exp));
        chk("frame_done_cnt", 32'(fd_seen), 32'(fd_exp));
        chk("abort_cnt", 32'(abort_seen), 32'(abort_exp));
        chk("idle_oe", 32'(spi_miso_oe), 32'd0);
        chk("idle_miso", 32'(spi_miso), 32'd1);
    endtask

    initial begin
        int acc, n, room, np, nbytes, pbits;
        logic [7:0] got;
        repeat (3) @(negedge axi_aclk);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_miso", 32'(spi_miso), 32'd1);
        chk("rst_oe", 32'(spi_miso_oe), 32'd0);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        chk("tready_after_rst", 32'(s_axis_tready), 32'd1);

        push(8'hA5, 1'b1);
        window(1, 0, 0);
        chk("single_tready", 32'(s_axis_tready), 32'd1);
        chk("single_fifo_empty", 32'(dut.empty), 32'd1);

        push(8'h01, 1'b0);
        push(8'h80, 1'b0);
        push(8'h3C, 1'b0);
        window(3, 0, 0);

        window(2, 0, 0);

        // Fill with tvalid held until backpressure.
        acc = 0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_axis_tdata = 8'($urandom);
            s_axis_tlast = 1'($urandom);
            if (!s_axis_tready) break;
            model.push_back({s_axis_tlast, s_axis_tdata});
            acc++;
            @(negedge axi_aclk);
        end
        s_axis_tvalid = 1'b0;
        chk("accepts_to_full", 32'(acc), 32'd16);
        repeat (3) @(negedge axi_aclk);
        chk("full_tready", 32'(s_axis_tready), 32'd0);
        // cs rise: 2 sync stages + detect + LOAD pop -> tready back high 4 cycles later.
        spi_cs = 1'b1;
        n = 0;
        while (!s_axis_tready && n < 10) begin
            @(negedge axi_aclk);
            n++;
        end
        chk("tready_after_pop", 32'(n), 32'd4);
        repeat (4) @(negedge axi_aclk);
        window(16, 0, 1);

        push(8'hF0, 1'b0);
        push(8'h0F, 1'b1);
        window(0, 3, 0);
        window(1, 0, 0);

        for (int i = 0; i < 4; i++) push(8'($urandom), 1'b0);
        cs_on();
        xfer(5, 1'b1, got);
        axi_aresetn = 1'b0;
        spi_cs = 1'b0;
        spi_clk = 1'b0;
        #1;
        chk("midrst_oe", 32'(spi_miso_oe), 32'd0);
        chk("midrst_miso", 32'(spi_miso), 32'd1);
        chk("midrst_tready", 32'(s_axis_tready), 32'd0);
        repeat (2) @(negedge axi_aclk);
        chk("midrst_tready_hold", 32'(s_axis_tready), 32'd0);
        axi_aresetn = 1'b1;
        model.delete();
        @(negedge axi_aclk);
        chk("postrst_tready", 32'(s_axis_tready), 32'd1);
        repeat (4) @(negedge axi_aclk);
        window(1, 0, 0);

        for (int r = 0; r < 8; r++) begin
            room = 16 - model.size();
            np = $urandom_range(0, (room < 5) ? room : 5);
            for (int j = 0; j < np; j++) push(8'($urandom), 1'($urandom));
            nbytes = $urandom_range(1, 4);
            pbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            window(nbytes, pbits, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
